// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - width derivation and output formatting helpers for mac_window_acc
package mac_pkg;

   localparam int MAX_W = 64;

   function automatic int clog2(input int n);
      int r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int prod_w(input int in_w, input int w_w);
      return in_w + w_w;
   endfunction

   function automatic int acc_w(input int in_w, input int w_w, input int n);
      return prod_w(in_w, w_w) + clog2(n);
   endfunction

   // Clamps to the out_w signed range when sat is set; the caller keeps the low out_w bits.
   function automatic logic signed [MAX_W-1:0] sat_trunc(input logic signed [MAX_W-1:0] v,
                                                        input int out_w, input bit sat);
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = ~hi;
      if (sat && (v > hi)) return hi;
      if (sat && (v < lo)) return lo;
      return v;
   endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// rtl/mac_mul_stage.sv - operand capture (S0) and signed product register (S1) with valid pipe
module mac_mul_stage
   import mac_pkg::*;
#(
   parameter int IN_W = 4,
   parameter int W_W  = 4,
   localparam int PROD_W = IN_W + W_W
) (
   input  logic                     clk,
   input  logic                     rstb,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic signed [IN_W-1:0]   in_a,
   input  logic signed [W_W-1:0]    in_b,
   output logic                     prod_valid,
   output logic signed [PROD_W-1:0] prod
);

   logic signed [IN_W-1:0]   a_q, a_d;
   logic signed [W_W-1:0]    b_q, b_d;
   logic                     v0_q, v0_d;
   logic                     v1_q, v1_d;
   logic signed [PROD_W-1:0] prod_q, prod_d;

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      prod_d = prod_q;
      if (in_valid) begin
         a_d = in_a;
         b_d = in_b;
      end
      if (v0_q) prod_d = PROD_W'(a_q) * PROD_W'(b_q);
      // clear kills both the sample arriving now and the one already in S0
      v0_d = in_valid & ~clear;
      v1_d = v0_q & ~clear;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         a_q    <= '0;
         b_q    <= '0;
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
         prod_q <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         v0_q   <= v0_d;
         v1_q   <= v1_d;
         prod_q <= prod_d;
      end
   end

   assign prod_valid = v1_q;
   assign prod       = prod_q;

endmodule

// File: rtl/mac_window_acc.sv
// rtl/mac_window_acc.sv - windowed signed multiply-accumulate: N products summed per result
module mac_window_acc
   import mac_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int W_W   = 4,
   parameter int N     = 9,
   parameter int OUT_W = 12,
   parameter int SAT   = 0
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    clear,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  IN,
   input  logic signed [W_W-1:0]   W,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] OUT
);

   localparam int PROD_W = prod_w(IN_W, W_W);
   localparam int ACC_W  = acc_w(IN_W, W_W, N);
   localparam int CNT_W  = clog2(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic                     prod_valid;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext, base, sum;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic signed [OUT_W-1:0]  out_q, out_d;
   logic                     out_valid_q, out_valid_d;

   mac_mul_stage #(.IN_W(IN_W), .W_W(W_W)) u_mul (
      .clk        (clk),
      .rstb       (rstb),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_a       (IN),
      .in_b       (W),
      .prod_valid (prod_valid),
      .prod       (prod)
   );

   always_comb begin
      prod_ext    = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      base        = (count_q == '0) ? '0 : acc_q;
      sum         = base + prod_ext;
      acc_d       = acc_q;
      count_d     = count_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      if (clear) begin
         acc_d   = '0;
         count_d = '0;
      end else if (prod_valid) begin
         if (count_q == LAST) begin
            out_d       = OUT_W'(sat_trunc(MAX_W'(sum), OUT_W, SAT != 0));
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
         end else begin
            acc_d   = sum;
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         acc_q       <= '0;
         count_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         count_q     <= count_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign OUT       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/mac_window_acc.md
Name: mac_window_acc

Overview:
Parametrised signed multiply-accumulate with a windowed sum. Each window covers N valid samples. The block multiplies IN by W on every valid sample and accumulates N products into one signed result. The result is presented on OUT with a one-cycle out_valid pulse. It generalises the fixed 4x4-bit, 9-cycle MAC: widths, window length and overflow mode are configurable, and it adds input qualification, window abort and selectable saturation.

Parameters:
IN_W, 4, signed width of IN
W_W, 4, signed width of W
N, 9, products per window (2..1024)
OUT_W, 12, signed width of OUT
SAT, 0, overflow mode: 0 = wrap (two's-complement truncation), 1 = saturate to OUT_W range

Ports:
clk  input  1  rising-edge clock
rstb  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: discard the window in progress and all in-flight samples
in_valid  input  1  IN/W carry a sample this cycle
IN  input  IN_W  signed operand
W  input  W_W  signed operand
out_valid  output  1  one-cycle pulse: OUT holds a new window result
OUT  output  OUT_W  signed window sum, held until the next result

Behaviour:
- Reset: rstb low asynchronously clears all state. Outputs become OUT=0 and out_valid=0. Internally, stage valids=0, window counter=0, accumulator=0. Reset mid-window discards the partial sum.
- Full-precision widths:
  - PROD_W = IN_W+W_W.
  - ACC_W = PROD_W+clog2(N).
  - The accumulator never overflows internally. Products and the accumulator are sign-extended.
- Pipeline:
  - S0, edge E0: register IN, W, in_valid.
  - S1, edge E1: register the product and its valid.
  - S2, edge E2: update the accumulator, counter and output.
- Latency: the Nth valid sample sampled at E0 gives OUT and out_valid=1 after E2. out_valid is high for exactly one cycle.
- Samples with in_valid=0 are ignored. Gaps of any length are allowed within a window.
- Window counter at S2, counting valid products 0..N-1:
  - count==0: acc <= prod.
  - Otherwise: acc <= acc+prod.
  - count==N-1: OUT <= fmt(acc+prod), out_valid <= 1, count <= 0.
- Back-to-back windows: with continuous in_valid, out_valid pulses every N cycles. The product following the Nth is the first of the next window, with no lost or duplicated samples.
- fmt() when ACC_W>OUT_W:
  - SAT=0: keep the low OUT_W bits.
  - SAT=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- fmt() when ACC_W<=OUT_W: sign-extend.
- clear=1 at an edge:
  - Counter=0, acc=0, S0/S1 valids=0, out_valid=0.
  - OUT keeps its last value.
  - A sample presented in the same cycle as clear is discarded (clear wins).
- Results from a window aborted by clear are never emitted. The next window starts from the first valid sample after clear.
- OUT changes only on an out_valid cycle or reset.

Decomposition:
- Package mac_pkg:
  - clog2 function.
  - PROD_W/ACC_W derivation function.
  - sat_trunc function (signed resize with SAT option).
- One natural sub-module, mac_mul_stage: S0/S1 operand and product registers with valid pipe, parameterised IN_W/W_W.
- The window counter, accumulator and output format stay in mac_window_acc.

Test Plan:
1. Defaults, 9 consecutive valid samples IN=2, W=3 -> OUT=54. out_valid pulses once, two edges after the 9th sample; OUT holds 54 afterwards.
2. Defaults, IN=-8, W=-8 for 18 continuous samples -> two pulses 9 cycles apart, each with OUT=576. Corner product, no overflow at OUT_W=12.
3. Defaults, in_valid alternating 1/0, IN=1, W=1, 9 valid samples -> OUT=9. Exactly one pulse, after the 9th valid sample; none on gap cycles.
4. Defaults, 5 samples of (4,4), then clear for one cycle together with a valid sample, then 9 samples IN=1, W=-1 -> no pulse for the aborted window; OUT=-9 on the next pulse.
5. OUT_W=8, 9 samples of (7,7), sum 441:
   - SAT=1 -> OUT=127.
   - SAT=1 with 9 samples of (-8,7), sum -504 -> OUT=-128.
   - SAT=0 with (7,7) -> OUT=-71.
6. Defaults: rstb low asynchronously after 4 samples -> OUT=0 and out_valid=0 without a clock edge. After release, 9 samples of (3,3) -> OUT=81.
